// File: rtl/vsram_pkg.sv
// Shared definitions for the virtual-SRAM link: frame layout, word widths,
// master FSM state encoding and a frame-building helper. Both the master and
// any slave model take the frame layout from here.
package vsram_pkg;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 16;
  localparam int FRAME_W   = 36;
  localparam int WE_BIT    = 35;
  localparam int WDATA_MSB = 34;
  localparam int WDATA_LSB = 19;
  localparam int ADDR_MSB  = 5;
  localparam int ADDR_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Assemble a link frame; the reserved bits between wdata and addr stay zero.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic              we,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata
  );
    logic [FRAME_W-1:0] f;
    f                        = '0;
    f[WE_BIT]                = we;
    f[WDATA_MSB:WDATA_LSB]   = wdata;
    f[ADDR_MSB:ADDR_LSB]     = addr;
    return f;
  endfunction

endpackage

// File: rtl/vsram_phase_cnt.sv
// Phase timer for the vsram master: a down-counter reloaded with CLK_DIV-1
// at the start of every link phase; tc_o marks the last cycle of the phase.
module vsram_phase_cnt #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic tc_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vsram_phase_cnt: CLK_DIV must be at least 1");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload at phase start, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/vsram_master.sv
// Initiator side of the virtual-SRAM link. Turns one CPU data-port request
// into a single framed transfer: SETUP (select + frame), STROBE (one sck
// high phase, slave writes on its rising edge), HOLD (frame kept stable),
// then a one-cycle DONE. All link outputs come straight from flops.
module vsram_master
  import vsram_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  input  logic               wr_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  output logic               ready_o,
  output logic               done_o,
  output logic [DATA_W-1:0]  rdata_o,
  output logic               sck_o,
  output logic               cs_n_o,
  output logic [FRAME_W-1:0] mosi_o,
  input  logic [DATA_W-1:0]  miso_i
);

  state_e             state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               sck_q;
  logic               cs_n_q;
  logic               ready_q;
  logic               done_q;

  logic               load_s;
  logic               tc_s;

  vsram_phase_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load_s),
    .tc_o   (tc_s)
  );

  // Restart the phase timer on acceptance and at every phase boundary.
  always_comb begin
    load_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      SETUP, STROBE, HOLD: load_s = tc_s;
      default: load_s = 1'b0;
    endcase
  end

  // Link FSM with registered link/handshake outputs and read-data capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      frame_q <= '0;
      rdata_q <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (req_i) begin
            frame_q <= build_frame(wr_i, addr_i, wdata_i);
            cs_n_q  <= 1'b0;
            ready_q <= 1'b0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (tc_s) begin
            sck_q   <= 1'b1;
            state_q <= STROBE;
          end
        end
        STROBE: begin
          if (tc_s) begin
            sck_q   <= 1'b0;
            state_q <= HOLD;
            // Slave drives miso combinationally from the addressed word.
            if (!frame_q[WE_BIT]) begin
              rdata_q <= miso_i;
            end
          end
        end
        HOLD: begin
          if (tc_s) begin
            cs_n_q  <= 1'b1;
            frame_q <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          frame_q <= '0;
          sck_q   <= 1'b0;
          cs_n_q  <= 1'b1;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign sck_o   = sck_q;
  assign cs_n_o  = cs_n_q;
  assign mosi_o  = frame_q;

endmodule

// File: tb/tb_vsram_master.sv
// Directed bench for vsram_master: three builds (CLK_DIV = 2, 1, 4), each
// talking to its own behavioural vsram slave with a preloaded 64x16 memory.
module tb_vsram_master;
  import vsram_pkg::*;

  localparam int NDUT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NDUT-1:0]   req;
  logic [NDUT-1:0]   ready;
  logic [NDUT-1:0]   done;
  logic [NDUT-1:0]   sck;
  logic [NDUT-1:0]   cs_n;
  logic              wr;
  logic [5:0]        addr;
  logic [15:0]       wdata;
  logic [35:0]       mosi  [NDUT];
  logic [15:0]       rdata [NDUT];
  logic [15:0]       miso  [NDUT];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Free-running cycle count used to time acceptances.
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int CD = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [15:0] dmem [64];
    int rises = 0;
    int dones = 0;

    initial begin
      for (int i = 0; i < 64; i++) dmem[i] = 16'hA000 + 16'(i);
    end

    assign miso[g] = dmem[mosi[g][5:0]];

    // Slave: writes on sck rising edge when the frame's we bit is set.
    always @(posedge sck[g]) begin
      rises <= rises + 1;
      if (mosi[g][35]) dmem[mosi[g][5:0]] <= mosi[g][34:19];
    end

    // Count done pulses away from the active edge.
    always @(negedge clk) if (done[g] === 1'b1) dones <= dones + 1;

    vsram_master #(.CLK_DIV(CD)) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .req_i   (req[g]),
      .wr_i    (wr),
      .addr_i  (addr),
      .wdata_i (wdata),
      .ready_o (ready[g]),
      .done_o  (done[g]),
      .rdata_o (rdata[g]),
      .sck_o   (sck[g]),
      .cs_n_o  (cs_n[g]),
      .mosi_o  (mosi[g]),
      .miso_i  (miso[g])
    );
  end

  task automatic chk_vec(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int rises_of(input int k);
    case (k)
      0:       return g_dut[0].rises;
      1:       return g_dut[1].rises;
      default: return g_dut[2].rises;
    endcase
  endfunction

  function automatic int dones_of(input int k);
    case (k)
      0:       return g_dut[0].dones;
      1:       return g_dut[1].dones;
      default: return g_dut[2].dones;
    endcase
  endfunction

  function automatic logic [15:0] peek0(input int a);
    return g_dut[0].dmem[a];
  endfunction

  task automatic wait_ready(input int k);
    int t;
    t = 0;
    while (ready[k] !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
  endtask

  // One transaction on build k. lat = clock edges from the accepting edge
  // until done is seen (capped at 100); frame = mosi in the first SETUP cycle.
  task automatic run(input int k, input logic w, input logic [5:0] a, input logic [15:0] d,
                     input bit hold, output int lat, output logic [35:0] frame,
                     output logic [15:0] rd, output int nrise, output int acc);
    int r0;
    wait_ready(k);
    wr = w; addr = a; wdata = d; req[k] = 1'b1;
    r0 = rises_of(k);
    @(posedge clk); #1;
    acc = cyc;
    if (!hold) req[k] = 1'b0;
    frame = mosi[k];
    lat = 0;
    while (done[k] !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata[k];
    nrise = rises_of(k) - r0;
  endtask

  initial begin
    int lat, nr, ac, ac_prev, d0, t;
    logic [35:0] fr;
    logic [15:0] rd;

    req = '0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state of every build.
    for (int k = 0; k < NDUT; k++) begin
      chk_vec("rst_ready", 36'(ready[k]), 36'd1);
      chk_vec("rst_done",  36'(done[k]),  36'd0);
      chk_vec("rst_sck",   36'(sck[k]),   36'd0);
      chk_vec("rst_cs_n",  36'(cs_n[k]),  36'd1);
      chk_vec("rst_mosi",  mosi[k],       36'd0);
      chk_vec("rst_rdata", 36'(rdata[k]), 36'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Write BEEF to word 5: we=1, BEEF<<19, addr 5.
    run(0, 1'b1, 6'h05, 16'hBEEF, 1'b0, lat, fr, rd, nr, ac);
    chk_vec("wr_frame",      fr,            36'hD_F778_0005);
    chk_vec("wr_latency",    36'(lat),      36'd6);
    chk_vec("wr_sck_rises",  36'(nr),       36'd1);
    chk_vec("wr_done_cs_n",  36'(cs_n[0]),  36'd1);
    chk_vec("wr_done_mosi",  mosi[0],       36'd0);
    chk_vec("wr_done_ready", 36'(ready[0]), 36'd0);
    chk_vec("wr_dmem5",      36'(peek0(5)), 36'hBEEF);

    // Read it back, then a write must leave rdata alone.
    run(0, 1'b0, 6'h05, 16'h0000, 1'b0, lat, fr, rd, nr, ac);
    chk_vec("rd_frame",   fr,       36'h0_0000_0005);
    chk_vec("rd_latency", 36'(lat), 36'd6);
    chk_vec("rd_data",    36'(rd),  36'hBEEF);
    @(posedge clk); #1;
    chk_vec("ready_after_done", 36'(ready[0]), 36'd1);
    chk_vec("done_one_cycle",   36'(done[0]),  36'd0);
    run(0, 1'b1, 6'h07, 16'h1111, 1'b0, lat, fr, rd, nr, ac);
    chk_vec("wr7_frame",  fr,      36'h8_8888_0007);
    chk_vec("rdata_kept", 36'(rd), 36'hBEEF);

    // req held high: idle + 3 phases of 2 + done cycle = 8 cycles per access.
    run(0, 1'b1, 6'h00, 16'h1234, 1'b1, lat, fr, rd, nr, ac);
    ac_prev = ac;
    chk_vec("b2b_frame0", fr,      36'h8_91A0_0000);
    chk_vec("b2b_rises0", 36'(nr), 36'd1);
    run(0, 1'b0, 6'h3F, 16'h0000, 1'b1, lat, fr, rd, nr, ac);
    chk_vec("b2b_period1", 36'(ac - ac_prev), 36'd8);
    chk_vec("b2b_addr63",  36'(fr[5:0]),      36'h3F);
    chk_vec("b2b_rd63",    36'(rd),           36'hA03F);
    chk_vec("b2b_rises1",  36'(nr),           36'd1);
    ac_prev = ac;
    run(0, 1'b1, 6'h3F, 16'h5678, 1'b1, lat, fr, rd, nr, ac);
    chk_vec("b2b_period2", 36'(ac - ac_prev), 36'd8);
    chk_vec("b2b_frame63", fr,                36'hA_B3C0_003F);
    ac_prev = ac;
    run(0, 1'b0, 6'h00, 16'h0000, 1'b1, lat, fr, rd, nr, ac);
    req[0] = 1'b0;
    chk_vec("b2b_period3", 36'(ac - ac_prev), 36'd8);
    chk_vec("b2b_rd0",     36'(rd),           36'h1234);

    // Inputs changed and req pulsed while busy: ignored.
    wait_ready(0);
    wr = 1'b1; addr = 6'h12; wdata = 16'h1357; req[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0; wr = 1'b0; addr = 6'h2A; wdata = 16'hFFFF;
    d0 = dones_of(0);
    chk_vec("busy_frame_setup", mosi[0], 36'h8_9AB8_0012);
    @(posedge clk); #1; req[0] = 1'b1;
    @(posedge clk); #1; req[0] = 1'b0;
    chk_vec("busy_sck_high",     36'(sck[0]), 36'd1);
    chk_vec("busy_frame_strobe", mosi[0],     36'h8_9AB8_0012);
    repeat (10) @(posedge clk);
    #1;
    chk_vec("busy_single_done", 36'(dones_of(0) - d0), 36'd1);
    chk_vec("busy_dmem12",      36'(peek0(18)),        36'h1357);
    chk_vec("busy_dmem2a",      36'(peek0(42)),        36'hA02A);
    chk_vec("busy_ready",       36'(ready[0]),         36'd1);

    // CLK_DIV=1 and CLK_DIV=4 builds.
    run(1, 1'b1, 6'h05, 16'hBEEF, 1'b0, lat, fr, rd, nr, ac);
    chk_vec("div1_wr_frame",   fr,       36'hD_F778_0005);
    chk_vec("div1_wr_latency", 36'(lat), 36'd3);
    chk_vec("div1_wr_rises",   36'(nr),  36'd1);
    run(1, 1'b0, 6'h05, 16'h0000, 1'b0, lat, fr, rd, nr, ac);
    chk_vec("div1_rd_latency", 36'(lat), 36'd3);
    chk_vec("div1_rd_data",    36'(rd),  36'hBEEF);
    run(2, 1'b1, 6'h05, 16'hC0DE, 1'b0, lat, fr, rd, nr, ac);
    chk_vec("div4_wr_latency", 36'(lat), 36'd12);
    chk_vec("div4_wr_rises",   36'(nr),  36'd1);
    run(2, 1'b0, 6'h05, 16'h0000, 1'b0, lat, fr, rd, nr, ac);
    chk_vec("div4_rd_latency", 36'(lat), 36'd12);
    chk_vec("div4_rd_data",    36'(rd),  36'hC0DE);

    // Reset in the middle of a write's STROBE phase.
    wait_ready(0);
    wr = 1'b1; addr = 6'h20; wdata = 16'h4444; req[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    d0 = dones_of(0);
    t = 0;
    while (sck[0] !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk_vec("abort_in_strobe", 36'(sck[0]), 36'd1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk_vec("abort_sck",   36'(sck[0]),   36'd0);
    chk_vec("abort_cs_n",  36'(cs_n[0]),  36'd1);
    chk_vec("abort_mosi",  mosi[0],       36'd0);
    chk_vec("abort_ready", 36'(ready[0]), 36'd1);
    chk_vec("abort_done",  36'(done[0]),  36'd0);
    chk_vec("abort_rdata", 36'(rdata[0]), 36'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_vec("abort_no_done", 36'(dones_of(0) - d0), 36'd0);
    run(0, 1'b0, 6'h05, 16'h0000, 1'b0, lat, fr, rd, nr, ac);
    chk_vec("recover_rd",      36'(rd),  36'hBEEF);
    chk_vec("recover_latency", 36'(lat), 36'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
